// File: rtl/vreg_seq_pkg.sv
// Shared types and helpers for the vector register-group address sequencer.
package vreg_seq_pkg;

    localparam int MAX_EMUL_LOG2 = 3;

    localparam logic [2:0] VLMUL_M1   = 3'b000;
    localparam logic [2:0] VLMUL_M2   = 3'b001;
    localparam logic [2:0] VLMUL_M4   = 3'b010;
    localparam logic [2:0] VLMUL_M8   = 3'b011;
    localparam logic [2:0] VLMUL_RSVD = 3'b100;
    localparam logic [2:0] VLMUL_MF8  = 3'b101;
    localparam logic [2:0] VLMUL_MF4  = 3'b110;
    localparam logic [2:0] VLMUL_MF2  = 3'b111;

    typedef enum logic {IDLE, BUSY} seq_state_e;

    // Returns {reserved, L}; fractional settings occupy one register, so L = 0.
    function automatic logic [2:0] lmul_log2(input logic [2:0] vlmul);
        logic [2:0] res;
        case (vlmul)
            VLMUL_M1:   res = 3'b000;
            VLMUL_M2:   res = 3'b001;
            VLMUL_M4:   res = 3'b010;
            VLMUL_M8:   res = 3'b011;
            VLMUL_RSVD: res = 3'b100;
            default:    res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vreg_port_addr.sv
// One operand port: beat address from the captured group base, plus the
// alignment check applied to the incoming request at accept time.
module vreg_port_addr #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [1:0]            emul,
    input  logic [1:0]            max_emul,
    input  logic [2:0]            k,
    input  logic [ADDR_WIDTH-1:0] chk_base,
    input  logic [2:0]            chk_emul,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  misalign
);

    logic [1:0]            shift;
    logic [ADDR_WIDTH-1:0] mask;

    // Narrower ports advance once every 2^(max_emul - emul) beats.
    assign shift    = max_emul - emul;
    assign addr     = base + {{(ADDR_WIDTH-3){1'b0}}, k >> shift};

    assign mask     = ({{(ADDR_WIDTH-1){1'b0}}, 1'b1} << chk_emul) - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign misalign = |(chk_base & mask);

endmodule

// File: rtl/vreg_group_sequencer.sv
// Expands one decoded vector instruction into per-register beats carrying
// every operand port's physical register address.
module vreg_group_sequencer
    import vreg_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_PORTS  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [2:0]                      req_vlmul,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS-1:0]            req_wide,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0] out_addr,
    output logic                            out_first,
    output logic                            out_last,
    output logic                            out_err,
    output logic                            busy,
    output seq_state_e                      state
);

    // Handshakes: a transfer happens on a rising clk edge where valid & ready
    // are both high; valid never drops and payload never changes until then.

    logic [2:0]                      lmul_info;
    logic                            req_rsvd;
    logic                            req_frac;
    logic [NUM_PORTS-1:0][2:0]       req_emul;
    logic [2:0]                      req_max;
    logic [NUM_PORTS-1:0]            req_misalign;
    logic                            req_err;
    logic                            accept;
    logic                            advance;

    logic [NUM_PORTS*ADDR_WIDTH-1:0] base_q;
    logic [NUM_PORTS-1:0][1:0]       emul_q;
    logic [1:0]                      max_q;
    logic [2:0]                      k;
    logic [2:0]                      k_last;

    assign lmul_info = lmul_log2(req_vlmul);
    assign req_rsvd  = lmul_info[2];
    assign req_frac  = req_vlmul[2] & ~req_rsvd;

    always_comb begin
        req_emul = '0;
        req_max  = 3'd0;
        req_err  = req_rsvd | (|req_misalign);
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_emul[p] = req_frac ? 3'd0 : ({1'b0, lmul_info[1:0]} + {2'b00, req_wide[p]});
            if (req_emul[p] > req_max)
                req_max = req_emul[p];
            if (req_emul[p] > 3'(MAX_EMUL_LOG2))
                req_err = 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        vreg_port_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_port (
            .base     (base_q[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .emul     (emul_q[p]),
            .max_emul (max_q),
            .k        (k),
            .chk_base (req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .chk_emul (req_emul[p]),
            .addr     (out_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .misalign (req_misalign[p])
        );
    end

    // Only combinational path from out_ready: lets the next request load on the last beat.
    assign req_ready = ~out_valid | (out_ready & out_last);
    assign busy      = out_valid;
    assign accept    = req_valid & req_ready;
    assign advance   = out_valid & out_ready;
    assign k_last    = 3'((4'd1 << max_q) - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            k         <= 3'd0;
            base_q    <= '0;
            emul_q    <= '0;
            max_q     <= 2'd0;
        end else if (accept) begin
            state     <= BUSY;
            out_valid <= 1'b1;
            out_first <= 1'b1;
            k         <= 3'd0;
            base_q    <= req_addr;
            if (req_err) begin
                // Zero shift and k = 0 make the error beat echo req_addr.
                out_err  <= 1'b1;
                out_last <= 1'b1;
                emul_q   <= '0;
                max_q    <= 2'd0;
            end else begin
                out_err  <= 1'b0;
                out_last <= (req_max == 3'd0);
                for (int p = 0; p < NUM_PORTS; p++)
                    emul_q[p] <= req_emul[p][1:0];
                max_q    <= req_max[1:0];
            end
        end else if (advance) begin
            if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
                out_err   <= 1'b0;
            end else begin
                k         <= k + 3'd1;
                out_first <= 1'b0;
                out_last  <= ((k + 3'd1) == k_last);
            end
        end
    end

endmodule

// File: tb/tb_vreg_group_sequencer.sv
// Directed bench for vreg_group_sequencer with hand-computed beat vectors.
module tb_vreg_group_sequencer;
    import vreg_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_vlmul;
    logic [14:0] req_addr;
    logic [2:0]  req_wide;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_addr;
    logic        out_first;
    logic        out_last;
    logic        out_err;
    logic        busy;
    seq_state_e  state;

    int n_tests = 0;
    int n_fail  = 0;

    // {busy, out_valid, out_err, out_first, out_last, vs2, vs1, vd}
    logic [19:0] exp_q[$];

    vreg_group_sequencer #(.ADDR_WIDTH(5), .NUM_PORTS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_vlmul (req_vlmul),
        .req_addr  (req_addr),
        .req_wide  (req_wide),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_first (out_first),
        .out_last  (out_last),
        .out_err   (out_err),
        .busy      (busy),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] mk(input logic e, input logic f, input logic l,
                                       input logic [4:0] vd, input logic [4:0] vs1,
                                       input logic [4:0] vs2);
        return {1'b1, 1'b1, e, f, l, vs2, vs1, vd};
    endfunction

    function automatic logic [19:0] observed();
        return {busy, out_valid, out_err, out_first, out_last, out_addr};
    endfunction

    task automatic check_beat(input string tag, input bit do_pop);
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 32'(exp_q.size()), 32'd1);
        end else begin
            check(tag, 32'(observed()), 32'(exp_q[0]));
            if (do_pop) void'(exp_q.pop_front());
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [2:0] vlmul, input logic [4:0] vd, input logic [4:0] vs1,
                         input logic [4:0] vs2, input logic [2:0] wide);
        int waited;
        req_vlmul = vlmul;
        req_addr  = {vs2, vs1, vd};
        req_wide  = wide;
        req_valid = 1'b1;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) check("issue_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 40) begin
            if (out_valid) check_beat(tag, 1'b1);
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, {30'd0, out_valid, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_vlmul = 3'b000;
        req_addr  = '0;
        req_wide  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outs", 32'(observed()), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_state", 32'(state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // LMUL 4, no widening
        exp_q.push_back(mk(0, 1, 0, 8, 4, 12));
        exp_q.push_back(mk(0, 0, 0, 9, 5, 13));
        exp_q.push_back(mk(0, 0, 0, 10, 6, 14));
        exp_q.push_back(mk(0, 0, 1, 11, 7, 15));
        issue(VLMUL_M4, 8, 4, 12, 3'b000);
        check("m4_state", 32'(state), 32'(BUSY));
        drain("m4");

        // LMUL 2 with vd widened to EMUL 4
        exp_q.push_back(mk(0, 1, 0, 4, 2, 6));
        exp_q.push_back(mk(0, 0, 0, 5, 2, 6));
        exp_q.push_back(mk(0, 0, 0, 6, 3, 7));
        exp_q.push_back(mk(0, 0, 1, 7, 3, 7));
        issue(VLMUL_M2, 4, 2, 6, 3'b001);
        drain("wide");

        // Illegal groups: EMUL 16, misaligned vd, reserved vlmul
        exp_q.push_back(mk(1, 1, 1, 0, 8, 16));
        issue(VLMUL_M8, 0, 8, 16, 3'b001);
        drain("err_emul");
        exp_q.push_back(mk(1, 1, 1, 9, 4, 12));
        issue(VLMUL_M4, 9, 4, 12, 3'b000);
        drain("err_align");
        exp_q.push_back(mk(1, 1, 1, 8, 4, 12));
        issue(VLMUL_RSVD, 8, 4, 12, 3'b000);
        drain("err_rsvd");
        check("err_state", 32'(state), 32'(IDLE));

        // Fractional: widening and odd addresses still legal, one beat
        exp_q.push_back(mk(0, 1, 1, 3, 5, 7));
        issue(VLMUL_MF2, 3, 5, 7, 3'b111);
        drain("frac");

        // Backpressure 1-0-0-1 then back-to-back request on the last beat
        exp_q.push_back(mk(0, 1, 0, 8, 4, 12));
        exp_q.push_back(mk(0, 0, 0, 9, 5, 13));
        exp_q.push_back(mk(0, 0, 0, 10, 6, 14));
        exp_q.push_back(mk(0, 0, 1, 11, 7, 15));
        exp_q.push_back(mk(0, 1, 1, 1, 2, 3));
        out_ready = 1'b1;
        issue(VLMUL_M4, 8, 4, 12, 3'b000);
        check_beat("bp_b0", 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        check_beat("bp_hold1", 1'b0);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_beat("bp_hold2", 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        check_beat("bp_b1", 1'b1);
        @(negedge clk);
        check_beat("bp_b2", 1'b1);
        @(negedge clk);
        check_beat("bp_b3", 1'b1);
        req_vlmul = VLMUL_M1;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_wide  = 3'b000;
        req_valid = 1'b1;
        check("b2b_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check_beat("b2b_beat", 1'b1);
        @(negedge clk);
        check("b2b_idle", 32'(out_valid), 32'd0);

        // Reset during beat 2 of an 8-beat request
        exp_q.push_back(mk(0, 1, 0, 0, 8, 16));
        exp_q.push_back(mk(0, 0, 0, 1, 9, 17));
        exp_q.push_back(mk(0, 0, 0, 2, 10, 18));
        issue(VLMUL_M8, 0, 8, 16, 3'b000);
        check_beat("rst8_b0", 1'b1);
        @(negedge clk);
        check_beat("rst8_b1", 1'b1);
        @(negedge clk);
        check_beat("rst8_b2", 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst8_valid", {30'd0, out_valid, busy}, 32'd0);
        check("rst8_state", 32'(state), 32'(IDLE));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst8_nobeat", 32'(out_valid), 32'd0);
        exp_q.push_back(mk(0, 1, 0, 4, 6, 8));
        exp_q.push_back(mk(0, 0, 1, 5, 7, 9));
        issue(VLMUL_M2, 4, 6, 8, 3'b000);
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
